// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands one bit per clock, LSB first,
// through a single full-adder cell built from two half adders.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               last_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   s_sr_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               s0_s;
    logic               c0_s;
    logic               c1_s;
    logic               bit_s;
    logic               carry_next_s;
    logic [WIDTH-1:0]   s_shift_s;

    half_adder u_ha0 (.x(a_sr_r[0]), .y(b_sr_r[0]), .s(s0_s),  .c(c0_s));
    half_adder u_ha1 (.x(s0_s),      .y(carry_r),   .s(bit_s), .c(c1_s));

    assign carry_next_s = c0_s | c1_s;
    assign s_shift_s    = {bit_s, s_sr_r[WIDTH-1:1]};

    // Next-state decode; last_s marks the edge that processes the MSB.
    always_comb begin
        state_s = state_r;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                if (cnt_r == LAST_CNT) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = ADD;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/result shift registers, carry, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            s_sr_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        carry_r <= 1'b0;
                        cnt_r   <= '0;
                    end
                end
                ADD: begin
                    a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
                    s_sr_r  <= s_shift_s;
                    carry_r <= carry_next_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        sum_r  <= s_shift_s;
                        cout_r <= carry_next_s;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    assign busy = (state_r == ADD);
    assign done = (state_r == DONE);
    assign sum  = sum_r;
    assign cout = cout_r;
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: cycle-level behavioural model for the 8-bit instance plus
// directed literal checks, and an exhaustive sweep on a 4-bit instance.

module tb_serial_add_seq;
    logic       clk = 1'b0;
    logic       rst_n, start, start4;
    logic [7:0] a, b, sum;
    logic [3:0] a4, b4, sum4;
    logic       busy, done, cout, busy4, done4, cout4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_q[$];

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: an accepted operation at edge t0 is busy for edges t0..t0+7, done after
    // edge t0+8 (when the result appears) and returns to idle at edge t0+9.
    int         m_active = 0;
    int         m_t0 = 0;
    logic [7:0] m_a, m_b, m_sum;
    logic       m_cout;
    logic [8:0] m_res;

    always @(posedge clk) begin
        int idle;
        cyc++;
        idle = (m_active == 0);
        if (!rst_n) begin
            m_active = 0;
            m_sum    = 8'd0;
            m_cout   = 1'b0;
        end else begin
            if (m_active != 0 && cyc == m_t0 + 8) begin
                m_res  = {1'b0, m_a} + {1'b0, m_b};
                m_sum  = m_res[7:0];
                m_cout = m_res[8];
            end else if (m_active != 0 && cyc == m_t0 + 9) begin
                m_active = 0;
            end
            if (idle != 0 && start) begin
                m_active = 1;
                m_t0     = cyc;
                m_a      = a;
                m_b      = b;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", busy, (m_active != 0 && cyc - m_t0 < 8) ? 1 : 0);
        chk("done", done, (m_active != 0 && cyc - m_t0 == 8) ? 1 : 0);
        chk("sum",  sum,  m_sum);
        chk("cout", cout, m_cout);
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_q.push_back(cyc);
        end
    end

    task automatic wait_done(output int seen);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] es, input logic ec);
        int t0, seen;
        @(negedge clk);
        busy_cnt = 0;
        start = 1'b1; a = ta; b = tb;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        t0 = cyc;
        wait_done(seen);
        if (seen != 0) begin
            chk("latency", cyc - t0, 8);
            chk("busy_cycles", busy_cnt, 8);
            chk("sum_lit", sum, es);
            chk("cout_lit", cout, ec);
        end
        @(negedge clk);
        chk("done_len", done, 0);
    endtask

    initial begin
        int t0, seen, dc;
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        a = 8'd0; b = 8'd0; a4 = 4'd0; b4 = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;

        op8(8'd3, 8'd5, 8'd8, 1'b0);
        op8(8'd255, 8'd1, 8'd0, 1'b1);
        op8(8'd255, 8'd255, 8'd254, 1'b1);
        op8(8'd0, 8'd0, 8'd0, 1'b0);

        // Extra start pulses during ADD must be ignored.
        @(negedge clk);
        dc = done_cnt;
        start = 1'b1; a = 8'd10; b = 8'd20;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0; a = 8'hA5; b = 8'h5A;
        while (cyc < t0 + 2) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 1'b0; a = 8'hFF; b = 8'h0F;
        while (cyc < t0 + 7) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 30);
        repeat (12) @(negedge clk);
        chk("ign_done_count", done_cnt - dc, 1);

        // Reset in the middle of an addition discards it.
        dc = done_cnt;
        start = 1'b1; a = 8'd100; b = 8'd100;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        while (cyc < t0 + 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - dc, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        op8(8'd7, 8'd9, 8'd16, 1'b0);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        done_q.delete();
        start = 1'b1; a = 8'd200; b = 8'd100;
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("hold_count_ok", (done_q.size() >= 3) ? 1 : 0, 1);
        for (int i = 1; i < done_q.size(); i++)
            chk("hold_spacing", done_q[i] - done_q[i-1], 10);
        chk("hold_sum", sum, 44);
        chk("hold_cout", cout, 1);

        // Exhaustive 4-bit sweep.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            logic [4:0] exp5;
            v = 8'(i);
            exp5 = {1'b0, v[3:0]} + {1'b0, v[7:4]};
            @(negedge clk);
            start4 = 1'b1; a4 = v[3:0]; b4 = v[7:4];
            @(negedge clk);
            start4 = 1'b0; a4 = ~a4; b4 = ~b4;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done4) begin
                    seen = 1;
                    break;
                end
            end
            if (seen == 0) chk("done4_timeout", 0, 1);
            else chk("sweep4", {cout4, sum4}, exp5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
